regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised, scoreboarded register file for the RV32I core: 2^ADDR_WIDTH architectural registers with register 0 hard-wired to zero, NUM_READ combinational read ports with optional same-cycle write bypass, and one write port. A per-register pending bit tracks destinations of in-flight multi-cycle producers (loads), so decode can stall on true RAW hazards. The block is asynchronously cleared and replaces the fixed 32×32 two-port register file between decode and writeback.

## Interface
Parameters:
- DATA_WIDTH, 32: register width in bits.
- ADDR_WIDTH, 5: address width; the file has 2^ADDR_WIDTH entries, entry 0 constant zero.
- NUM_READ, 2: number of read ports, at least 1.
- BYPASS, 1: when 1, a write in the current cycle is forwarded to matching read ports.
- TAP_ADDR, 10: register exposed on `tap` (a0 by default).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rd_addr  in  NUM_READ×ADDR_WIDTH  read addresses.
- rd_data  out  NUM_READ×DATA_WIDTH  read data.
- rd_ready  out  NUM_READ  read operand is valid (not pending).
- we  in  1  write enable.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- issue_valid  in  1  mark `issue_addr` as pending.
- issue_addr  in  ADDR_WIDTH  destination of the in-flight producer.
- flush  in  1  clear all pending bits (pipeline squash).
- tap  out  DATA_WIDTH  stored value of register TAP_ADDR.
- pending_cnt  out  ADDR_WIDTH+1  number of registers currently pending.

## Operation
- Storage: entries 1..2^ADDR_WIDTH−1 are flops. Entry 0 is not stored: it reads as 0, its writes are ignored, and its pending bit is never set.
- Write: on a clock edge with `we`=1 and `wr_addr`≠0, the entry takes `wr_data`. The same edge clears that entry's pending bit, unless the priority rules below keep it set.
- Read (combinational, per port p):
  - `rd_addr[p]`=0 gives `rd_data`=0 and `rd_ready`=1.
  - If BYPASS=1, `we`=1 and `wr_addr`=`rd_addr[p]`≠0: `rd_data`=`wr_data` and `rd_ready`=1.
  - Otherwise `rd_data` is the stored value and `rd_ready` is the inverse of the entry's pending bit.
- Issue: on a clock edge with `issue_valid`=1 and `issue_addr`≠0, that entry's pending bit is set.
- Per-entry pending priority at each edge:
  - `flush` takes precedence over everything: the bit is cleared.
  - Otherwise an issue to that entry sets the bit. This wins over a simultaneous write to the same entry, because the new producer supersedes the old one. The write data is still stored.
  - Otherwise a write to that entry clears the bit.
  - Otherwise the bit holds.
- Issue while the entry is already pending: the bit stays set. No error is raised.
- pending_cnt: registered population count of the pending bits. It is updated on the same edge as the bits and always equals the popcount of the current state.
- tap: combinational from storage, with no bypass. It shows the new value from the cycle after the write.

## Timing
- Reset, asynchronous on `rst_n`=0: all entries 0, all pending bits 0, `pending_cnt`=0, `tap`=0, every `rd_ready`=1.
- Reset asserted mid-operation clears state immediately, regardless of `clk`.
- After deassertion, the first edge with `rst_n`=1 performs normal updates.
- Read latency: 0 cycles, combinational from the address.
- Write-to-read latency: 0 cycles with BYPASS=1, 1 cycle with BYPASS=0.
- Issue-to-stall: `rd_ready` drops in the cycle after the issue edge.
- Writeback-to-ready: same cycle with BYPASS=1, next cycle otherwise.
- `pending_cnt` range is 0..2^ADDR_WIDTH−1 and cannot overflow.

## Structure
- Package `regfile_pkg`:
  - default DATA_WIDTH / ADDR_WIDTH localparams;
  - `reg_addr_t` and `reg_data_t` typedefs;
  - constant `REG_ZERO`=0;
  - constant `REG_A0`=10.
- Sub-module `regfile_scoreboard`: holds the pending-bit vector, the set/clear priority logic and `pending_cnt`.
- `regfile_sb` holds storage, read muxing, bypass and the tap.

## Test plan
- Reset: with `rst_n` low, read every address on both ports → all `rd_data`=0, `rd_ready`=1, `tap`=0, `pending_cnt`=0.
- x0: write 0xDEADBEEF to addr 0, then read addr 0 → 0. Issue to addr 0 → `pending_cnt` stays 0.
- Bypass: write 0x12345678 to x5 while port 1 reads x5 → same cycle `rd_data[1]`=0x12345678. With BYPASS=0 → old value, then new value next cycle.
- Scoreboard:
  - issue x7 → next cycle `rd_ready` for x7 = 0 and `pending_cnt`=1;
  - write 0xA5 to x7 → `rd_ready`=1 (same cycle with bypass), `pending_cnt`=0 next cycle.
- Same-edge conflicts:
  - x7 pending; issue x7 and write x7=0x55 on one edge → x7 reads 0x55, `rd_ready`=0, `pending_cnt`=1;
  - issue x3 and x4, then `flush` with issue x9 → `pending_cnt`=0.
- Tap and mid-run reset:
  - write 0x2A to x10 → `tap`=0x2A on the next cycle;
  - with x10 pending, pulse `rst_n` low between edges → `tap`=0 and `pending_cnt`=0 immediately.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the scoreboarded register file.
// Default widths match the RV32I integer register file.
package regfile_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;

    typedef logic [DATA_WIDTH_DEF-1:0] reg_data_t;
    typedef logic [ADDR_WIDTH_DEF-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;
    localparam reg_addr_t REG_A0   = reg_addr_t'(10);

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-bit tracker for in-flight multi-cycle producers.
// Priority per entry: flush, then issue, then write clear, then hold.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         we,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic                         issue_valid,
    input  logic [ADDR_WIDTH-1:0]        issue_addr,
    input  logic                         flush,
    output logic [(1<<ADDR_WIDTH)-1:0]   pending,
    output logic [ADDR_WIDTH:0]          pending_cnt
);

    localparam int NUM_ENT = 1 << ADDR_WIDTH;

    logic [NUM_ENT-1:0] pending_nxt;
    logic [ADDR_WIDTH:0] cnt_nxt;

    always_comb begin
        pending_nxt = pending;
        for (int i = 1; i < NUM_ENT; i++) begin
            if (flush) begin
                pending_nxt[i] = 1'b0;
            end else if (issue_valid && issue_addr == ADDR_WIDTH'(i)) begin
                pending_nxt[i] = 1'b1;
            end else if (we && wr_addr == ADDR_WIDTH'(i)) begin
                pending_nxt[i] = 1'b0;
            end
        end
        // x0 never has a producer to wait on.
        pending_nxt[0] = 1'b0;
    end

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < NUM_ENT; i++) begin
            cnt_nxt = cnt_nxt + {{ADDR_WIDTH{1'b0}}, pending_nxt[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending     <= '0;
            pending_cnt <= '0;
        end else begin
            pending     <= pending_nxt;
            pending_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Scoreboarded register file: x0 hard-wired to zero, N read ports with
// optional write bypass, one write port, and per-register pending bits.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int NUM_READ   = 2,
    parameter int BYPASS     = 1,
    parameter int TAP_ADDR   = int'(REG_A0)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_READ-1:0][ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_READ-1:0][DATA_WIDTH-1:0] rd_data,
    output logic [NUM_READ-1:0]                rd_ready,
    input  logic                               we,
    input  logic [ADDR_WIDTH-1:0]              wr_addr,
    input  logic [DATA_WIDTH-1:0]              wr_data,
    input  logic                               issue_valid,
    input  logic [ADDR_WIDTH-1:0]              issue_addr,
    input  logic                               flush,
    output logic [DATA_WIDTH-1:0]              tap,
    output logic [ADDR_WIDTH:0]                pending_cnt
);

    localparam int NUM_ENT = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(REG_ZERO);

    logic [DATA_WIDTH-1:0] regs [NUM_ENT-1:1];
    logic [DATA_WIDTH-1:0] view [NUM_ENT];
    logic [NUM_ENT-1:0]    pending;
    logic                  wr_hit;

    assign wr_hit = we && (wr_addr != ZERO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NUM_ENT; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_hit) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Full-size read view with the constant-zero entry folded in.
    always_comb begin
        view[0] = '0;
        for (int i = 1; i < NUM_ENT; i++) begin
            view[i] = regs[i];
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_READ; p++) begin
            rd_data[p]  = '0;
            rd_ready[p] = 1'b1;
            if (rd_addr[p] != ZERO) begin
                if ((BYPASS != 0) && we && (wr_addr == rd_addr[p])) begin
                    rd_data[p]  = wr_data;
                    rd_ready[p] = 1'b1;
                end else begin
                    rd_data[p]  = view[rd_addr[p]];
                    rd_ready[p] = !pending[rd_addr[p]];
                end
            end
        end
    end

    assign tap = view[TAP_ADDR];

    regfile_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .we          (we),
        .wr_addr     (wr_addr),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .flush       (flush),
        .pending     (pending),
        .pending_cnt (pending_cnt)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb with bypass on (dut) and off (dut_nb).
// Both instances share every input.
module tb_regfile_sb;
    import regfile_pkg::*;

    logic              clk;
    logic              rst_n;
    logic [1:0][4:0]   rd_addr;
    logic [1:0][31:0]  rd_data;
    logic [1:0]        rd_ready;
    logic [1:0][31:0]  rd_data_nb;
    logic [1:0]        rd_ready_nb;
    logic              we;
    logic [4:0]        wr_addr;
    logic [31:0]       wr_data;
    logic              issue_valid;
    logic [4:0]        issue_addr;
    logic              flush;
    logic [31:0]       tap;
    logic [31:0]       tap_nb;
    logic [5:0]        pending_cnt;
    logic [5:0]        pending_cnt_nb;

    int total_cnt;
    int pass_cnt;

    regfile_sb #(.BYPASS(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_ready    (rd_ready),
        .we          (we),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .flush       (flush),
        .tap         (tap),
        .pending_cnt (pending_cnt)
    );

    regfile_sb #(.BYPASS(0)) dut_nb (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data_nb),
        .rd_ready    (rd_ready_nb),
        .we          (we),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .flush       (flush),
        .tap         (tap_nb),
        .pending_cnt (pending_cnt_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        we          = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        issue_valid = 1'b0;
        issue_addr  = '0;
        flush       = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        for (int a = 0; a < 32; a++) begin
            rd_addr[0] = 5'(a);
            rd_addr[1] = 5'(a);
            #1;
            total_cnt++;
            if (rd_data[0] !== 32'h0 || rd_data[1] !== 32'h0 ||
                rd_ready !== 2'b11) begin
                $display("FAIL reset_read a=%0d got d0=%h d1=%h rdy=%b want 0 0 11",
                         a, rd_data[0], rd_data[1], rd_ready);
            end else pass_cnt++;
        end
        total_cnt++;
        if (tap !== 32'h0 || pending_cnt !== 6'd0) begin
            $display("FAIL reset_tap_cnt got tap=%h cnt=%0d want 0 0", tap, pending_cnt);
        end else pass_cnt++;
        total_cnt++;
        if (rd_ready_nb !== 2'b11 || pending_cnt_nb !== 6'd0) begin
            $display("FAIL reset_nb got rdy=%b cnt=%0d want 11 0",
                     rd_ready_nb, pending_cnt_nb);
        end else pass_cnt++;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_x0();
        we = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEADBEEF;
        rd_addr[0] = 5'd0;
        #1;
        total_cnt++;
        if (rd_data[0] !== 32'h0) begin
            $display("FAIL x0_bypass got %h want 0", rd_data[0]);
        end else pass_cnt++;
        step();
        idle();
        issue_valid = 1'b1; issue_addr = 5'd0;
        step();
        idle();
        #1;
        total_cnt++;
        if (rd_data[0] !== 32'h0 || rd_ready[0] !== 1'b1 || pending_cnt !== 6'd0) begin
            $display("FAIL x0_read got d=%h rdy=%b cnt=%0d want 0 1 0",
                     rd_data[0], rd_ready[0], pending_cnt);
        end else pass_cnt++;
        step();
    endtask

    task automatic test_bypass();
        rd_addr[1] = 5'd5;
        we = 1'b1; wr_addr = 5'd5; wr_data = 32'h12345678;
        #1;
        total_cnt++;
        if (rd_data[1] !== 32'h12345678 || rd_ready[1] !== 1'b1) begin
            $display("FAIL bypass_same got d=%h rdy=%b want 12345678 1",
                     rd_data[1], rd_ready[1]);
        end else pass_cnt++;
        total_cnt++;
        if (rd_data_nb[1] !== 32'h0) begin
            $display("FAIL nobypass_old got %h want 0", rd_data_nb[1]);
        end else pass_cnt++;
        step();
        idle();
        #1;
        total_cnt++;
        if (rd_data_nb[1] !== 32'h12345678 || rd_data[1] !== 32'h12345678) begin
            $display("FAIL bypass_next got nb=%h b=%h want 12345678",
                     rd_data_nb[1], rd_data[1]);
        end else pass_cnt++;
        step();
    endtask

    task automatic test_scoreboard();
        rd_addr[0] = 5'd7;
        issue_valid = 1'b1; issue_addr = 5'd7;
        #1;
        total_cnt++;
        if (rd_ready[0] !== 1'b1) begin
            $display("FAIL issue_before_edge got rdy=%b want 1", rd_ready[0]);
        end else pass_cnt++;
        step();
        idle();
        #1;
        total_cnt++;
        if (rd_ready[0] !== 1'b0 || pending_cnt !== 6'd1 ||
            rd_ready_nb[0] !== 1'b0 || pending_cnt_nb !== 6'd1) begin
            $display("FAIL issue_stall got rdy=%b cnt=%0d nb_rdy=%b nb_cnt=%0d want 0 1 0 1",
                     rd_ready[0], pending_cnt, rd_ready_nb[0], pending_cnt_nb);
        end else pass_cnt++;
        we = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5;
        #1;
        total_cnt++;
        if (rd_ready[0] !== 1'b1 || rd_data[0] !== 32'hA5 || rd_ready_nb[0] !== 1'b0) begin
            $display("FAIL wb_same got rdy=%b d=%h nb_rdy=%b want 1 a5 0",
                     rd_ready[0], rd_data[0], rd_ready_nb[0]);
        end else pass_cnt++;
        step();
        idle();
        #1;
        total_cnt++;
        if (pending_cnt !== 6'd0 || rd_ready_nb[0] !== 1'b1 || rd_data_nb[0] !== 32'hA5) begin
            $display("FAIL wb_next got cnt=%0d nb_rdy=%b nb_d=%h want 0 1 a5",
                     pending_cnt, rd_ready_nb[0], rd_data_nb[0]);
        end else pass_cnt++;
        step();
    endtask

    task automatic test_conflict();
        rd_addr[0] = 5'd7;
        issue_valid = 1'b1; issue_addr = 5'd7;
        step();
        we = 1'b1; wr_addr = 5'd7; wr_data = 32'h55;
        step();
        idle();
        #1;
        total_cnt++;
        if (rd_data[0] !== 32'h55 || rd_ready[0] !== 1'b0 || pending_cnt !== 6'd1) begin
            $display("FAIL issue_vs_write got d=%h rdy=%b cnt=%0d want 55 0 1",
                     rd_data[0], rd_ready[0], pending_cnt);
        end else pass_cnt++;
        issue_valid = 1'b1; issue_addr = 5'd3;
        step();
        issue_addr = 5'd4;
        step();
        idle();
        #1;
        total_cnt++;
        if (pending_cnt !== 6'd3) begin
            $display("FAIL three_pending got cnt=%0d want 3", pending_cnt);
        end else pass_cnt++;
        rd_addr[1] = 5'd9;
        flush = 1'b1; issue_valid = 1'b1; issue_addr = 5'd9;
        step();
        idle();
        #1;
        total_cnt++;
        if (pending_cnt !== 6'd0 || rd_ready !== 2'b11) begin
            $display("FAIL flush_wins got cnt=%0d rdy=%b want 0 11", pending_cnt, rd_ready);
        end else pass_cnt++;
        step();
    endtask

    task automatic test_tap_reset();
        we = 1'b1; wr_addr = 5'd10; wr_data = 32'h2A;
        #1;
        total_cnt++;
        if (tap !== 32'h0) begin
            $display("FAIL tap_no_bypass got %h want 0", tap);
        end else pass_cnt++;
        step();
        idle();
        #1;
        total_cnt++;
        if (tap !== 32'h2A || tap_nb !== 32'h2A) begin
            $display("FAIL tap_next got %h nb=%h want 2a", tap, tap_nb);
        end else pass_cnt++;
        issue_valid = 1'b1; issue_addr = 5'd10;
        step();
        idle();
        rd_addr[0] = 5'd10;
        #1;
        total_cnt++;
        if (pending_cnt !== 6'd1 || rd_ready[0] !== 1'b0) begin
            $display("FAIL a0_pending got cnt=%0d rdy=%b want 1 0", pending_cnt, rd_ready[0]);
        end else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (tap !== 32'h0 || pending_cnt !== 6'd0 || rd_ready[0] !== 1'b1 ||
            rd_data[0] !== 32'h0) begin
            $display("FAIL async_reset got tap=%h cnt=%0d rdy=%b d=%h want 0 0 1 0",
                     tap, pending_cnt, rd_ready[0], rd_data[0]);
        end else pass_cnt++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        rd_addr[0] = 5'd5;
        rd_addr[1] = 5'd6;
        we = 1'b1; wr_addr = 5'd5; wr_data = 32'h77;
        step();
        wr_addr = 5'd6; wr_data = 32'h99;
        issue_valid = 1'b1; issue_addr = 5'd5;
        step();
        idle();
        #1;
        total_cnt++;
        if (rd_data_nb[0] !== 32'h77 || rd_data_nb[1] !== 32'h99 ||
            rd_ready_nb !== 2'b10 || pending_cnt_nb !== 6'd1) begin
            $display("FAIL back_to_back got d0=%h d1=%h rdy=%b cnt=%0d want 77 99 10 1",
                     rd_data_nb[0], rd_data_nb[1], rd_ready_nb, pending_cnt_nb);
        end else pass_cnt++;
        step();
    endtask

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        rd_addr   = '0;
        idle();
        test_reset();
        test_x0();
        test_bypass();
        test_scoreboard();
        test_conflict();
        test_tap_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
